systolic_feeder_2x2: RTL
========================

Name: systolic_feeder_2x2

Overview:
Operand sequencer that drives the 2x2 systolic multiply array. It accepts matrices A and B in one start handshake and clears the array accumulators. It then streams A rows (west edge) and B columns (north edge) in the diagonal skew the array needs, waits for the wavefront to drain, and signals completion. It sits between the host/register interface and the array's in_00_N, in_00_W, in_10_W and in_01_N inputs.

Parameters:
DW, 16, operand element width in bits.
DRAIN_CYCLES, 2, cycles after the last feed phase before done; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse/level; sampled only in IDLE
a_flat  input  4*DW  matrix A packed {a11,a10,a01,a00}; a00 in LSBs
b_flat  input  4*DW  matrix B packed {b11,b10,b01,b00}; b00 in LSBs
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; array results valid this cycle
arr_clr  output  1  one-cycle accumulator clear request to the array, active-high
in_00_N  output  DW  north operand into PE00
in_00_W  output  DW  west operand into PE00
in_01_N  output  DW  north operand into PE01
in_10_W  output  DW  west operand into PE10

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - busy, done and arr_clr are 0.
  - All four operand outputs are 0.
  - Captured operand registers are 0.
  - Applies mid-operation with no completion pulse.
- All outputs are registered. Each value holds for the whole cycle the FSM spends in the listed state or phase.
- FSM states:
  - IDLE:
    - All outputs 0.
    - start=1 at a clock edge captures a_flat and b_flat and moves to CLEAR.
  - CLEAR (1 cycle): arr_clr=1, busy=1, operand outputs 0. Then FEED with phase 0.
  - FEED (3 cycles, phase counter 0..2). Operand output values per phase:
    - phase0: in_00_W=a00, in_00_N=b00, in_10_W=0, in_01_N=0.
    - phase1: in_00_W=a01, in_00_N=b10, in_10_W=a10, in_01_N=b01.
    - phase2: in_00_W=0, in_00_N=0, in_10_W=a11, in_01_N=b11.
    - After phase2 the FSM moves to DRAIN.
  - DRAIN: DRAIN_CYCLES cycles, operand outputs 0, drain counter counts down. At 0 the FSM moves to DONE.
  - DONE (1 cycle): done=1, busy=1, operand outputs 0. Then IDLE.
- Latency: with start sampled at edge E, CLEAR occupies cycle E+1 and done is high in cycle E+5+DRAIN_CYCLES (E+7 at default).
- Minimum start-to-start period is DRAIN_CYCLES+6 cycles: one IDLE cycle is always inserted after DONE.
- start while busy is ignored; there is no queueing.
- A held-high start relaunches on the first IDLE edge.
- a_flat and b_flat may change freely after the capture edge. Only the captured copy is streamed.
- Operand values pass through bit-exact. The block does no arithmetic and no sign handling.
- Simultaneous reset deassertion and start: reset deassertion is synchronous-released upstream. The first edge with reset=1 may accept start.

Decomposition:
- Shared package:
  - DW default.
  - FSM state encoding (IDLE, CLEAR, FEED, DRAIN, DONE).
  - Phase constants PH0..PH2.
  - Packed-element index constants (A00=0, A01=1, A10=2, A11=3, same for B).
- One natural sub-module, systolic_skew_sel: purely combinational. It maps phase plus captured operands to the four next-cycle operand values.
- The top holds the FSM, counters and output registers.

Test Plan:
- Basic feed: A={{1,2},{3,4}}, B={{5,6},{7,8}}, single start pulse.
  - CLEAR cycle has arr_clr=1.
  - Feed tuples (in_00_W,in_00_N,in_10_W,in_01_N) are (1,5,0,0), (2,7,3,6), (0,0,4,8).
  - done is high exactly 7 cycles after the start edge.
- End-to-end with the 2x2 array, clear driven from arr_clr: in the done cycle out_00=19, out_01=22, out_10=43, out_11=50.
- Ignored start and input change: pulse start at phase1 and change a_flat to all 9s during FEED.
  - Streamed values are unchanged.
  - Exactly one done pulse.
  - busy stays high throughout.
- Held start: hold start=1 for 30 cycles. done pulses occur every 8 cycles, each followed by one busy=0 cycle.
- Reset mid-op: assert reset low during FEED phase1.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No done pulse.
  - After release, a new start gives a correct full sequence.
- DRAIN_CYCLES=4: done appears 9 cycles after the start edge, and operands are 0 throughout DRAIN.

Source files
------------

// File: rtl/systolic_feeder_2x2_pkg.sv
// Shared types and constants for the 2x2 systolic operand feeder.
//   DW_DEFAULT : default operand element width
//   state_t    : feeder FSM states
//   PH0..PH2   : feed phase encodings
//   A00..B11   : element positions inside the packed {x11,x10,x01,x00} buses
package systolic_feeder_2x2_pkg;

  localparam int unsigned DW_DEFAULT = 16;
  localparam int unsigned PH_W       = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [PH_W-1:0] PH0 = 2'd0;
  localparam logic [PH_W-1:0] PH1 = 2'd1;
  localparam logic [PH_W-1:0] PH2 = 2'd2;

  localparam int unsigned A00 = 0;
  localparam int unsigned A01 = 1;
  localparam int unsigned A10 = 2;
  localparam int unsigned A11 = 3;
  localparam int unsigned B00 = 0;
  localparam int unsigned B01 = 1;
  localparam int unsigned B10 = 2;
  localparam int unsigned B11 = 3;

endpackage

// File: rtl/systolic_skew_sel.sv
// Combinational skew selector: maps a feed phase and the captured A/B
// matrices to the four operand values the array edge needs in that phase.
//   feed       : high when the values are for a FEED cycle (else all zero)
//   phase      : feed phase PH0..PH2
//   a, b       : captured matrices, packed {x11,x10,x01,x00}
//   in_*_c     : selected operand values (unregistered)
module systolic_skew_sel
  import systolic_feeder_2x2_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            feed,
  input  logic [PH_W-1:0] phase,
  input  logic [4*DW-1:0] a,
  input  logic [4*DW-1:0] b,
  output logic [DW-1:0]   in_00_n_c,
  output logic [DW-1:0]   in_00_w_c,
  output logic [DW-1:0]   in_01_n_c,
  output logic [DW-1:0]   in_10_w_c
);

  // Row 1 of A and column 1 of B lag row/column 0 by one phase.
  always_comb begin
    in_00_n_c = '0;
    in_00_w_c = '0;
    in_01_n_c = '0;
    in_10_w_c = '0;
    if (feed) begin
      case (phase)
        PH0: begin
          in_00_w_c = a[A00*DW +: DW];
          in_00_n_c = b[B00*DW +: DW];
        end
        PH1: begin
          in_00_w_c = a[A01*DW +: DW];
          in_00_n_c = b[B10*DW +: DW];
          in_10_w_c = a[A10*DW +: DW];
          in_01_n_c = b[B01*DW +: DW];
        end
        PH2: begin
          in_10_w_c = a[A11*DW +: DW];
          in_01_n_c = b[B11*DW +: DW];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer for the 2x2 systolic multiply array. Captures A and B on
// start, clears the array, streams skewed operands over three phases, waits
// DRAIN_CYCLES for the wavefront to settle and pulses done.
//   clk, reset        : clock, asynchronous active-low reset
//   start             : launch request, sampled only in IDLE
//   a_flat, b_flat    : matrices packed {x11,x10,x01,x00}
//   busy, done        : status (done is a one-cycle pulse)
//   arr_clr           : one-cycle accumulator clear to the array
//   in_00_N ... in_10_W : edge operands into the array
module systolic_feeder_2x2
  import systolic_feeder_2x2_pkg::*;
#(
  parameter int unsigned DW           = DW_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4*DW-1:0] a_flat,
  input  logic [4*DW-1:0] b_flat,
  output logic            busy,
  output logic            done,
  output logic            arr_clr,
  output logic [DW-1:0]   in_00_N,
  output logic [DW-1:0]   in_00_W,
  output logic [DW-1:0]   in_01_N,
  output logic [DW-1:0]   in_10_W
);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [CNT_W-1:0]    drain_q, drain_d;
  logic [4*DW-1:0]     a_q, b_q;
  logic                capture_c;
  logic [DW-1:0]       sel_00_n_c, sel_00_w_c, sel_01_n_c, sel_10_w_c;

  // State, counters and captured operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      if (capture_c) begin
        a_q <= a_flat;
        b_q <= b_flat;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    drain_d   = drain_q;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          capture_c = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        phase_d = PH0;
      end
      ST_FEED: begin
        if (phase_q == PH2) begin
          state_d = ST_DRAIN;
          drain_d = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand values are selected for the upcoming state so the registered
  // outputs line up with the state they belong to.
  systolic_skew_sel #(
    .DW (DW)
  ) u_skew_sel (
    .feed      (state_d == ST_FEED),
    .phase     (phase_d),
    .a         (a_q),
    .b         (b_q),
    .in_00_n_c (sel_00_n_c),
    .in_00_w_c (sel_00_w_c),
    .in_01_n_c (sel_01_n_c),
    .in_10_w_c (sel_10_w_c)
  );

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      arr_clr <= 1'b0;
      in_00_N <= '0;
      in_00_W <= '0;
      in_01_N <= '0;
      in_10_W <= '0;
    end else begin
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      arr_clr <= (state_d == ST_CLEAR);
      in_00_N <= sel_00_n_c;
      in_00_W <= sel_00_w_c;
      in_01_N <= sel_01_n_c;
      in_10_W <= sel_10_w_c;
    end
  end

endmodule
